// File: rtl/mc_move_monitor_pkg.sv
// Shared constants and types for the missionaries-cannibals move monitor.
package mc_move_monitor_pkg;

    localparam int DEF_N_M         = 3;
    localparam int DEF_N_C         = 3;
    localparam int DEF_BOAT_CAP    = 2;
    localparam int DEF_EXP_MOVES   = 11;
    localparam int DEF_STALL_LIMIT = 4;

    // Solver state codes: IDLE is 0, S1..S12 map to 1..12.
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_S1   = 4'd1;
    localparam logic [3:0] ST_S12  = 4'd12;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_TRACK,
        MON_DONE,
        MON_ERROR
    } mon_state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_INVALID   = 3'd1,
        ERR_CONSERVE  = 3'd2,
        ERR_BOAT      = 3'd3,
        ERR_PASSENGER = 3'd4,
        ERR_UNSAFE    = 3'd5,
        ERR_SEQUENCE  = 3'd6,
        ERR_STALL     = 3'd7
    } err_code_t;

endpackage

// File: rtl/mc_bank_safety.sv
// Flags a river bank where cannibals outnumber a nonzero group of missionaries.
module mc_bank_safety (
    input  logic [2:0] m,
    input  logic [2:0] c,
    output logic       unsafe
);

    assign unsafe = (m != 3'd0) && (c > m);

endmodule

// File: rtl/mc_move_monitor.sv
// Watches the solver's bank/boat snapshots, decodes each crossing and checks it,
// counting legal moves and latching the first violation.
module mc_move_monitor
    import mc_move_monitor_pkg::*;
#(
    parameter int N_M         = DEF_N_M,
    parameter int N_C         = DEF_N_C,
    parameter int BOAT_CAP    = DEF_BOAT_CAP,
    parameter int EXP_MOVES   = DEF_EXP_MOVES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] state,
    input  logic [2:0] missionaries_left,
    input  logic [2:0] cannibals_left,
    input  logic [2:0] missionaries_right,
    input  logic [2:0] cannibals_right,
    input  logic       boat_side,
    input  logic       solution_complete,
    input  logic       valid_state,
    output logic       move_valid,
    output logic [1:0] move_m,
    output logic [1:0] move_c,
    output logic       move_dir,
    output logic [3:0] move_count,
    output logic       done,
    output logic       error,
    output logic [2:0] error_code
);

    mon_state_t mon_q, mon_d;

    logic [3:0] prev_state;
    logic [2:0] prev_ml, prev_cl, prev_mr, prev_cr;
    logic       prev_boat;
    logic [2:0] stall_q, stall_d;

    logic       mv_d, dir_d, done_d, error_d, snap_load;
    logic [1:0] mm_d, mc_d;
    logic [3:0] count_d;
    logic [2:0] code_d;

    logic       arm, changed, abort, fail, legal, stall_hit;
    logic       unsafe_l, unsafe_r, dir_ok, pass_ok, is_final, final_ok;
    logic [3:0] dm, dc, abs_dm, abs_dc, pass_cnt, count_inc;
    err_code_t  chk_code, fail_code;

    mc_bank_safety u_left_bank (
        .m      (missionaries_left),
        .c      (cannibals_left),
        .unsafe (unsafe_l)
    );

    mc_bank_safety u_right_bank (
        .m      (missionaries_right),
        .c      (cannibals_right),
        .unsafe (unsafe_r)
    );

    assign arm = (state == ST_S1) && (missionaries_left == 3'(N_M)) && (cannibals_left == 3'(N_C))
              && (missionaries_right == 3'd0) && (cannibals_right == 3'd0) && !boat_side;

    assign changed = {state, missionaries_left, cannibals_left, missionaries_right, cannibals_right, boat_side}
                  != {prev_state, prev_ml, prev_cl, prev_mr, prev_cr, prev_boat};

    // Left-bank losses are positive on an outbound trip; negate on the return trip
    // so both directions reduce to "non-negative passengers, 1..BOAT_CAP total".
    assign dm       = {1'b0, prev_ml} - {1'b0, missionaries_left};
    assign dc       = {1'b0, prev_cl} - {1'b0, cannibals_left};
    assign abs_dm   = prev_boat ? -dm : dm;
    assign abs_dc   = prev_boat ? -dc : dc;
    assign dir_ok   = !abs_dm[3] && !abs_dc[3];
    assign pass_cnt = abs_dm + abs_dc;
    assign pass_ok  = dir_ok && (pass_cnt >= 4'd1) && (pass_cnt <= 4'(BOAT_CAP));

    always_comb begin
        chk_code = ERR_NONE;
        if (!valid_state)
            chk_code = ERR_INVALID;
        else if (({1'b0, missionaries_left} + {1'b0, missionaries_right}) != 4'(N_M)
              || ({1'b0, cannibals_left} + {1'b0, cannibals_right}) != 4'(N_C))
            chk_code = ERR_CONSERVE;
        else if (boat_side == prev_boat)
            chk_code = ERR_BOAT;
        else if (!pass_ok)
            chk_code = ERR_PASSENGER;
        else if (unsafe_l || unsafe_r)
            chk_code = ERR_UNSAFE;
        else if (state != prev_state + 4'd1)
            chk_code = ERR_SEQUENCE;
    end

    assign is_final  = (state == ST_S12) && solution_complete && (missionaries_left == 3'd0)
                    && (cannibals_left == 3'd0) && (missionaries_right == 3'(N_M))
                    && (cannibals_right == 3'(N_C)) && boat_side;
    assign count_inc = (move_count == 4'hF) ? 4'hF : move_count + 4'd1;
    assign final_ok  = (count_inc == 4'(EXP_MOVES));
    assign stall_hit = (stall_q == 3'(STALL_LIMIT - 1));
    assign abort     = changed && (state == ST_IDLE);
    assign fail      = changed && !abort && ((chk_code != ERR_NONE) || (is_final && !final_ok));
    assign legal     = changed && !abort && !fail;
    assign fail_code = (chk_code != ERR_NONE) ? chk_code : ERR_SEQUENCE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mon_q <= MON_IDLE;
        else
            mon_q <= mon_d;
    end

    always_comb begin
        mon_d = mon_q;
        if (clear) begin
            mon_d = MON_IDLE;
        end else begin
            case (mon_q)
                MON_IDLE:  if (arm) mon_d = MON_TRACK;
                MON_TRACK: begin
                    if (!changed && stall_hit)  mon_d = MON_ERROR;
                    else if (abort)             mon_d = MON_IDLE;
                    else if (fail)              mon_d = MON_ERROR;
                    else if (legal && is_final) mon_d = MON_DONE;
                end
                default: mon_d = mon_q;
            endcase
        end
    end

    // Next values of every registered output; DONE/ERROR simply hold.
    always_comb begin
        mv_d      = 1'b0;
        mm_d      = move_m;
        mc_d      = move_c;
        dir_d     = move_dir;
        count_d   = move_count;
        done_d    = done;
        error_d   = error;
        code_d    = error_code;
        stall_d   = stall_q;
        snap_load = 1'b0;
        if (clear) begin
            mm_d    = 2'd0;
            mc_d    = 2'd0;
            dir_d   = 1'b0;
            count_d = 4'd0;
            done_d  = 1'b0;
            error_d = 1'b0;
            code_d  = ERR_NONE;
            stall_d = 3'd0;
        end else begin
            case (mon_q)
                MON_IDLE: begin
                    if (arm) begin
                        snap_load = 1'b1;
                        count_d   = 4'd0;
                        stall_d   = 3'd0;
                    end
                end
                MON_TRACK: begin
                    snap_load = 1'b1;
                    if (!changed) begin
                        if (stall_hit) begin
                            error_d = 1'b1;
                            code_d  = ERR_STALL;
                        end else begin
                            stall_d = stall_q + 3'd1;
                        end
                    end else if (abort) begin
                        count_d = 4'd0;
                        stall_d = 3'd0;
                    end else if (fail) begin
                        error_d = 1'b1;
                        code_d  = fail_code;
                    end else begin
                        mv_d    = 1'b1;
                        mm_d    = abs_dm[1:0];
                        mc_d    = abs_dc[1:0];
                        dir_d   = prev_boat;
                        count_d = count_inc;
                        stall_d = 3'd0;
                        done_d  = is_final;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_valid <= 1'b0;
            move_m     <= 2'd0;
            move_c     <= 2'd0;
            move_dir   <= 1'b0;
            move_count <= 4'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= 3'd0;
            stall_q    <= 3'd0;
            prev_state <= 4'd0;
            prev_ml    <= 3'd0;
            prev_cl    <= 3'd0;
            prev_mr    <= 3'd0;
            prev_cr    <= 3'd0;
            prev_boat  <= 1'b0;
        end else begin
            move_valid <= mv_d;
            move_m     <= mm_d;
            move_c     <= mc_d;
            move_dir   <= dir_d;
            move_count <= count_d;
            done       <= done_d;
            error      <= error_d;
            error_code <= code_d;
            stall_q    <= stall_d;
            if (snap_load) begin
                prev_state <= state;
                prev_ml    <= missionaries_left;
                prev_cl    <= cannibals_left;
                prev_mr    <= missionaries_right;
                prev_cr    <= cannibals_right;
                prev_boat  <= boat_side;
            end
        end
    end

endmodule

// File: tb/tb_mc_move_monitor.sv
// Self-checking bench for mc_move_monitor: golden-run table, hand-built corner
// sequences, and a randomized walk checked against a rule-level reference model.
module tb_mc_move_monitor;

    logic       clk = 1'b0;
    logic       reset, clear;
    logic [3:0] state;
    logic [2:0] missionaries_left, cannibals_left, missionaries_right, cannibals_right;
    logic       boat_side, solution_complete, valid_state;
    logic       move_valid, move_dir, done, error;
    logic [1:0] move_m, move_c;
    logic [3:0] move_count;
    logic [2:0] error_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int st, ml, cl, mr, cr, boat, sc, vs;
    } snap_t;

    typedef struct {
        snap_t in;
        int    mv, mm, mc, dir, count, done;
    } vec_t;

    // Reference model state: mode 0 idle, 1 tracking, 2 done, 3 error.
    int    m_mode, m_stall, m_count, m_mv, m_mm, m_mc, m_dir, m_done, m_err, m_code;
    snap_t m_prev;

    const int g_ml[12] = '{3, 2, 3, 3, 3, 1, 2, 0, 0, 0, 0, 0};
    const int g_cl[12] = '{3, 2, 2, 0, 1, 1, 2, 2, 3, 1, 2, 0};

    mc_move_monitor dut (
        .clk                (clk),
        .reset              (reset),
        .clear              (clear),
        .state              (state),
        .missionaries_left  (missionaries_left),
        .cannibals_left     (cannibals_left),
        .missionaries_right (missionaries_right),
        .cannibals_right    (cannibals_right),
        .boat_side          (boat_side),
        .solution_complete  (solution_complete),
        .valid_state        (valid_state),
        .move_valid         (move_valid),
        .move_m             (move_m),
        .move_c             (move_c),
        .move_dir           (move_dir),
        .move_count         (move_count),
        .done               (done),
        .error              (error),
        .error_code         (error_code)
    );

    always #5 clk = ~clk;

    function automatic snap_t gold(int k);
        snap_t s;
        s.st = k + 1;  s.ml = g_ml[k];  s.cl = g_cl[k];
        s.mr = 3 - g_ml[k];  s.cr = 3 - g_cl[k];
        s.boat = k % 2;  s.sc = (k == 11) ? 1 : 0;  s.vs = 1;
        return s;
    endfunction

    function automatic int unsafe_bank(int m, int c);
        return (m > 0 && c > m) ? 1 : 0;
    endfunction

    // Violation code for a change from snapshot p to snapshot n, by the puzzle rules.
    function automatic int rule_code(snap_t p, snap_t n);
        int pm, pc;
        if (n.vs == 0) return 1;
        if (n.ml + n.mr != 3 || n.cl + n.cr != 3) return 2;
        if (n.boat == p.boat) return 3;
        pm = (p.boat == 0) ? p.ml - n.ml : n.ml - p.ml;
        pc = (p.boat == 0) ? p.cl - n.cl : n.cl - p.cl;
        if (pm < 0 || pc < 0 || pm + pc < 1 || pm + pc > 2) return 4;
        if (unsafe_bank(n.ml, n.cl) != 0 || unsafe_bank(n.mr, n.cr) != 0) return 5;
        if (n.st != ((p.st + 1) % 16)) return 6;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_stall = 0; m_count = 0; m_mv = 0; m_mm = 0; m_mc = 0;
        m_dir = 0; m_done = 0; m_err = 0; m_code = 0;
        m_prev = '{0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    task automatic model_step(snap_t n, bit clr);
        int code, newcount, fin;
        bit same;
        m_mv = 0;
        if (clr) begin
            m_mode = 0; m_stall = 0; m_count = 0; m_mm = 0; m_mc = 0;
            m_dir = 0; m_done = 0; m_err = 0; m_code = 0;
            return;
        end
        if (m_mode == 0) begin
            if (n.st == 1 && n.ml == 3 && n.cl == 3 && n.mr == 0 && n.cr == 0 && n.boat == 0) begin
                m_mode = 1; m_prev = n; m_count = 0; m_stall = 0;
            end
        end else if (m_mode == 1) begin
            same = (n.st == m_prev.st && n.ml == m_prev.ml && n.cl == m_prev.cl &&
                    n.mr == m_prev.mr && n.cr == m_prev.cr && n.boat == m_prev.boat);
            if (same) begin
                m_stall++;
                if (m_stall == 4) begin m_mode = 3; m_err = 1; m_code = 7; end
            end else if (n.st == 0) begin
                m_mode = 0; m_count = 0; m_stall = 0;
            end else begin
                code = rule_code(m_prev, n);
                fin = (n.st == 12 && n.sc == 1 && n.ml == 0 && n.cl == 0 && n.mr == 3 &&
                       n.cr == 3 && n.boat == 1) ? 1 : 0;
                newcount = (m_count == 15) ? 15 : m_count + 1;
                if (code == 0 && fin == 1 && newcount != 11) code = 6;
                if (code != 0) begin
                    m_mode = 3; m_err = 1; m_code = code;
                end else begin
                    m_mv = 1;
                    m_mm = (m_prev.boat == 0) ? m_prev.ml - n.ml : n.ml - m_prev.ml;
                    m_mc = (m_prev.boat == 0) ? m_prev.cl - n.cl : n.cl - m_prev.cl;
                    m_dir = m_prev.boat; m_count = newcount; m_stall = 0;
                    if (fin == 1) begin m_mode = 2; m_done = 1; end
                end
            end
            m_prev = n;
        end
    endtask

    task automatic checkVal(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int dut_word();
        return {move_valid, move_m, move_c, move_dir, move_count, done, error, error_code};
    endfunction

    function automatic int model_word();
        logic [14:0] w;
        w = {1'(m_mv), 2'(m_mm), 2'(m_mc), 1'(m_dir), 4'(m_count), 1'(m_done), 1'(m_err), 3'(m_code)};
        return int'(w);
    endfunction

    task automatic checkOutput(string name);
        checkVal(name, dut_word(), model_word());
    endtask

    task automatic applyStimulus(snap_t n, bit clr);
        state = 4'(n.st);
        missionaries_left = 3'(n.ml);  cannibals_left = 3'(n.cl);
        missionaries_right = 3'(n.mr); cannibals_right = 3'(n.cr);
        boat_side = 1'(n.boat); solution_complete = 1'(n.sc); valid_state = 1'(n.vs);
        clear = clr;
        @(posedge clk);
        model_step(n, clr);
        #1;
    endtask

    task automatic clearCycle();
        applyStimulus(gold(0), 1'b0 | 1'b1);
        state = 4'd0;
        checkOutput("clear");
    endtask

    task automatic runGold(int last);
        for (int k = 0; k <= last; k++) begin
            applyStimulus(gold(k), 1'b0);
            checkOutput($sformatf("gold_prefix_S%0d", k + 1));
        end
    endtask

    initial begin
        vec_t  gv[12];
        snap_t s;
        int    e_m[12]   = '{0, 1, 1, 0, 0, 2, 1, 2, 0, 0, 0, 0};
        int    e_c[12]   = '{0, 1, 0, 2, 1, 0, 1, 0, 1, 2, 1, 2};
        int    gidx, r, f;

        for (int k = 0; k < 12; k++) begin
            gv[k].in = gold(k);
            gv[k].mv = (k == 0) ? 0 : 1;
            gv[k].mm = e_m[k];
            gv[k].mc = e_c[k];
            gv[k].dir = (k == 0) ? 0 : (k + 1) % 2;
            gv[k].count = k;
            gv[k].done = (k == 11) ? 1 : 0;
        end

        reset = 1'b1; clear = 1'b0; state = 4'd0;
        missionaries_left = 3'd0; cannibals_left = 3'd0;
        missionaries_right = 3'd0; cannibals_right = 3'd0;
        boat_side = 1'b0; solution_complete = 1'b0; valid_state = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_outputs", dut_word(), 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] golden run");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(gv[k].in, 1'b0);
            checkVal($sformatf("gold_S%0d_valid", k + 1), move_valid, gv[k].mv);
            checkVal($sformatf("gold_S%0d_move", k + 1), {move_m, move_c, move_dir},
                     {2'(gv[k].mm), 2'(gv[k].mc), 1'(gv[k].dir)});
            checkVal($sformatf("gold_S%0d_count", k + 1), move_count, gv[k].count);
            checkVal($sformatf("gold_S%0d_done", k + 1), done, gv[k].done);
            checkVal($sformatf("gold_S%0d_error", k + 1), error, 0);
            checkOutput($sformatf("gold_S%0d_model", k + 1));
        end
        applyStimulus(gold(11), 1'b0);
        checkVal("done_hold_valid", move_valid, 0);
        checkVal("done_hold_done", done, 1);

        $display("[TB] clear after done, conservation fault");
        clearCycle();
        checkVal("clear_done", done, 0);
        runGold(2);
        s = '{4, 3, 0, 1, 3, 1, 0, 1};
        applyStimulus(s, 1'b0);
        checkVal("conserve_error", error, 1);
        checkVal("conserve_code", error_code, 2);
        checkVal("conserve_no_move", move_valid, 0);
        applyStimulus(gold(3), 1'b0);
        checkVal("error_sticky_code", error_code, 2);

        $display("[TB] clear with error set");
        clearCycle();
        checkVal("clear_error", dut_word(), 0);

        $display("[TB] unsafe bank");
        runGold(2);
        s = '{4, 1, 2, 2, 1, 1, 0, 1};
        applyStimulus(s, 1'b0);
        checkVal("unsafe_code", error_code, 5);
        checkVal("unsafe_no_move", move_valid, 0);
        clearCycle();

        $display("[TB] stall");
        runGold(3);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(gold(3), 1'b0);
            checkVal($sformatf("stall_hold%0d_error", i), error, 0);
        end
        applyStimulus(gold(3), 1'b0);
        checkVal("stall_error", error, 1);
        checkVal("stall_code", error_code, 7);
        clearCycle();
        runGold(3);
        repeat (3) applyStimulus(gold(3), 1'b0);
        applyStimulus(gold(4), 1'b0);
        checkVal("stall_reset_move", move_valid, 1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(gold(4), 1'b0);
            checkVal($sformatf("stall_rst_hold%0d_error", i), error, 0);
        end
        applyStimulus(gold(4), 1'b0);
        checkVal("stall_rst_code", error_code, 7);
        clearCycle();

        $display("[TB] abort and re-arm");
        runGold(5);
        s = '{0, 1, 1, 2, 2, 1, 0, 1};
        applyStimulus(s, 1'b0);
        checkVal("abort_count", move_count, 0);
        checkVal("abort_error", error, 0);
        applyStimulus(gold(6), 1'b0);
        checkVal("abort_idle_no_move", move_valid, 0);
        applyStimulus(gold(0), 1'b0);
        applyStimulus(gold(1), 1'b0);
        checkVal("rearm_move", move_valid, 1);
        checkVal("rearm_count", move_count, 1);

        $display("[TB] clear with same-cycle arm");
        applyStimulus(gold(0), 1'b1);
        applyStimulus(gold(1), 1'b0);
        checkVal("clear_arm_blocked", move_valid, 0);
        checkVal("clear_arm_count", move_count, 0);
        applyStimulus(gold(0), 1'b0);
        applyStimulus(gold(1), 1'b0);
        checkVal("late_arm_move", move_valid, 1);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(gold(2), 1'b0);
        applyStimulus(gold(3), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checkVal("midrun_reset", dut_word(), 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] randomized walk against reference model");
        gidx = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (m_mode >= 2) begin
                gidx = 0;
                if (r < 30) applyStimulus(gold(0), 1'b1);
                else applyStimulus(gold(int'($urandom_range(0, 11))), 1'b0);
            end else if (m_mode == 0) begin
                gidx = 0;
                if (r < 10) applyStimulus(gold(int'($urandom_range(1, 11))), 1'b0);
                else applyStimulus(gold(0), 1'b0);
            end else if (r < 60) begin
                if (gidx < 11) gidx++;
                applyStimulus(gold(gidx), 1'b0);
            end else if (r < 75) begin
                applyStimulus(gold(gidx), 1'b0);
            end else if (r < 90) begin
                s = gold((gidx < 11) ? gidx + 1 : gidx);
                f = $urandom_range(0, 7);
                case (f)
                    0: s.st = $urandom_range(1, 15);
                    1: s.ml = $urandom_range(0, 7);
                    2: s.cl = $urandom_range(0, 7);
                    3: s.mr = $urandom_range(0, 7);
                    4: s.cr = $urandom_range(0, 7);
                    5: s.boat = 1 - s.boat;
                    6: s.vs = 0;
                    default: s.sc = 1;
                endcase
                applyStimulus(s, 1'b0);
            end else if (r < 95) begin
                s = gold(gidx);
                s.st = 0;
                applyStimulus(s, 1'b0);
            end else begin
                applyStimulus(gold(gidx), 1'b1);
            end
            checkOutput($sformatf("random_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
